// File: rtl/unet_pvm_requant_acc_if.sv
// ---------------------------------------------------------------------------
// unet_pvm_requant_acc_if
//   Stream bundle for the requantizing accumulator.
//   Input stream : s_prod, s_valid, s_last, cfg_bias (producer -> block), s_ready (block -> producer)
//   Output stream: m_data, m_valid, m_ovf, m_len_err (block -> consumer), m_ready (consumer -> block)
//   Modports:
//     master - the side that produces products and consumes results (testbench / upstream glue)
//     slave  - the accumulator block itself
// ---------------------------------------------------------------------------
interface unet_pvm_requant_acc_if #(
    parameter int PROD_W = 47,
    parameter int ACC_W  = 57,
    parameter int OUT_W  = 16
);
    logic signed [PROD_W-1:0] s_prod;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic signed [ACC_W-1:0]  cfg_bias;
    logic signed [OUT_W-1:0]  m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_ovf;
    logic                     m_len_err;

    modport master (
        output s_prod, s_valid, s_last, cfg_bias, m_ready,
        input  s_ready, m_data, m_valid, m_ovf, m_len_err
    );

    modport slave (
        input  s_prod, s_valid, s_last, cfg_bias, m_ready,
        output s_ready, m_data, m_valid, m_ovf, m_len_err
    );
endinterface

// File: rtl/unet_pvm_requant_acc.sv
// ---------------------------------------------------------------------------
// unet_pvm_requant_acc
//   Accumulates a group of signed products (terminated by s_last) plus a
//   per-group bias, rescales with a round-half-up arithmetic right shift and
//   saturates to a signed OUT_W activation. One result per group.
//
//   Ports:
//     ap_clk  - clock, rising edge
//     ap_rst  - synchronous active-high reset
//     bus     - unet_pvm_requant_acc_if.slave
//               in : s_prod, s_valid, s_last, cfg_bias, m_ready
//               out: s_ready, m_data, m_valid, m_ovf, m_len_err
//
//   Optional feature macro: UNET_PVM_RELU_EN
//     defined   - negative saturated results are clamped to 0 (m_ovf unaffected)
//     undefined - signed saturated result passed through
// ---------------------------------------------------------------------------
module unet_pvm_requant_acc #(
    parameter int PROD_W = 47,
    parameter int CNT_W  = 10,
    parameter int ACC_W  = 57,
    parameter int SHIFT  = 11,
    parameter int OUT_W  = 16
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    unet_pvm_requant_acc_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic signed [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);

    state_t state, nxt;

    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic                    len_err;
    logic signed [OUT_W-1:0] data_q;
    logic                    ovf_q;

    logic s_rdy, m_vld, beat;
    logic signed [ACC_W-1:0] prod_x;

    // rounding / saturation path
    logic signed [ACC_W:0]   rsum, rsh;
    logic [ACC_W-OUT_W+1:0]  rhi;
    logic                    fits;
    logic signed [OUT_W-1:0] sat_val, res_val;

    assign beat   = bus.s_valid & s_rdy;
    assign prod_x = {{(ACC_W-PROD_W){bus.s_prod[PROD_W-1]}}, bus.s_prod};

    // state register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= IDLE;
        else        state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (beat) nxt = bus.s_last ? RND : ACC;
            ACC:  if (beat && bus.s_last) nxt = RND;
            RND:  nxt = OUT;
            OUT:  if (bus.m_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // output decode
    always_comb begin
        s_rdy = 1'b0;
        m_vld = 1'b0;
        case (state)
            IDLE, ACC: s_rdy = 1'b1;
            OUT:       m_vld = 1'b1;
            default:   ;
        endcase
    end

    // One extra bit of headroom so adding the half-LSB can never wrap.
    always_comb begin
        rsum = {acc[ACC_W-1], acc} + RND_HALF;
        rsh  = rsum >>> SHIFT;
        // Value fits OUT_W iff every bit from the OUT_W sign position up is equal.
        rhi  = rsh[ACC_W:OUT_W-1];
        fits = (&rhi) | ~(|rhi);
        if (fits)            sat_val = rsh[OUT_W-1:0];
        else if (rsh[ACC_W]) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else                 sat_val = {1'b0, {(OUT_W-1){1'b1}}};
`ifdef UNET_PVM_RELU_EN
        res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    // datapath registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc     <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (beat) begin
                    acc     <= bus.cfg_bias + prod_x;
                    cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
                    len_err <= 1'b0;
                end
                ACC: if (beat) begin
                    // acc keeps accumulating (and may wrap) past the length limit
                    acc <= acc + prod_x;
                    if (cnt == CNT_MAX) len_err <= 1'b1;
                    else                cnt     <= cnt + 1'b1;
                end
                RND: begin
                    data_q <= res_val;
                    ovf_q  <= ~fits;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready   = s_rdy;
    assign bus.m_valid   = m_vld;
    assign bus.m_data    = data_q;
    assign bus.m_ovf     = ovf_q;
    assign bus.m_len_err = len_err;

endmodule

// File: tb/tb_unet_pvm_requant_acc.sv
// ---------------------------------------------------------------------------
// tb_unet_pvm_requant_acc
//   Bench for unet_pvm_requant_acc: directed cases with literal expectations
//   plus randomized groups checked against a group-level arithmetic model.
// ---------------------------------------------------------------------------
module tb_unet_pvm_requant_acc;
    localparam int PROD_W = 47;
    localparam int CNT_W  = 10;
    localparam int ACC_W  = 57;
    localparam int SHIFT  = 11;
    localparam int OUT_W  = 16;
    localparam int MAX_LEN = (1 << CNT_W) - 1;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    unet_pvm_requant_acc_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    unet_pvm_requant_acc #(
        .PROD_W(PROD_W), .CNT_W(CNT_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint data;
        bit     ovf;
        bit     err;
    } res_t;

    res_t expq[$];
    bit   rand_mr = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer sum (wrapped to the accumulator width), floor((x + half)/2^SHIFT), clip.
    function automatic res_t requant(input logic signed [ACC_W-1:0] a, input bit err);
        longint r, maxv, minv;
        res_t   o;
        maxv  = (longint'(1) <<< (OUT_W-1)) - 1;
        minv  = -(longint'(1) <<< (OUT_W-1));
        r     = (longint'(a) + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        o.ovf = 1'b0;
        if (r > maxv) begin r = maxv; o.ovf = 1'b1; end
        if (r < minv) begin r = minv; o.ovf = 1'b1; end
`ifdef UNET_PVM_RELU_EN
        if (r < 0) r = 0;
`endif
        o.data = r;
        o.err  = err;
        return o;
    endfunction

    // Group-level model: observe accepted beats, emit one expectation per group.
    initial begin
        logic signed [ACC_W-1:0] g_acc;
        int g_n;
        bit in_group;
        g_acc = '0; g_n = 0; in_group = 1'b0;
        forever begin
            @(posedge ap_clk);
            if (ap_rst) begin
                expq.delete();
                in_group = 1'b0;
            end else if (bus.s_valid && bus.s_ready) begin
                if (!in_group) begin
                    g_acc = bus.cfg_bias + bus.s_prod;
                    g_n = 1;
                    in_group = 1'b1;
                end else begin
                    g_acc = g_acc + bus.s_prod;
                    g_n++;
                end
                if (bus.s_last) begin
                    expq.push_back(requant(g_acc, g_n > MAX_LEN));
                    in_group = 1'b0;
                end
            end
        end
    end

    // Compare every cycle the output is valid; a held result must keep matching.
    initial begin
        res_t e;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst && bus.m_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_m_valid", 1, 0);
                end else begin
                    e = expq[0];
                    chk("model_data", bus.m_data, e.data);
                    chk("model_ovf", bus.m_ovf, e.ovf);
                    chk("model_len_err", bus.m_len_err, e.err);
                    if (bus.m_ready) void'(expq.pop_front());
                end
            end
        end
    end

    // Random backpressure during the random phase.
    initial begin
        forever begin
            @(posedge ap_clk);
            #2;
            if (rand_mr) bus.m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_beat(input logic signed [PROD_W-1:0] p, input bit last,
                             input logic signed [ACC_W-1:0] b);
        int n;
        bit done;
        n = 0; done = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_prod   = p;
        bus.s_last   = last;
        bus.cfg_bias = b;
        while (!done) begin
            @(posedge ap_clk);
            done = bus.s_ready;
            #1;
            n++;
            if (!done && n > 50) begin
                chk("beat_timeout", 0, 1);
                done = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.m_valid && n < 20) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk({name, "_valid"}, bus.m_valid, 1);
    endtask

    task automatic expect_out(input string name, input longint d, input bit ovf, input bit err);
        wait_valid(name);
        chk({name, "_data"}, bus.m_data, d);
        chk({name, "_ovf"}, bus.m_ovf, ovf);
        chk({name, "_len_err"}, bus.m_len_err, err);
        bus.m_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.m_ready = 1'b0;
        chk({name, "_drop"}, bus.m_valid, 0);
    endtask

    function automatic logic signed [PROD_W-1:0] rnd_prod();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       return r[PROD_W-1:0];
            1:       return {{(PROD_W-16){r[15]}}, r[15:0]};
            default: return {{(PROD_W-27){r[26]}}, r[26:0]};
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] rnd_bias();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return {{(ACC_W-16){r[15]}}, r[15:0]};
            2:       return r[ACC_W-1:0];
            default: return {{(ACC_W-27){r[26]}}, r[26:0]};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [PROD_W-1:0] pmax, pmin;
        int n, len, idle;
        pmax = {1'b0, {(PROD_W-1){1'b1}}};
        pmin = {1'b1, {(PROD_W-1){1'b0}}};

        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_prod = '0;
        bus.cfg_bias = '0;  bus.m_ready = 1'b0;
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_ovf", bus.m_ovf, 0);
        chk("rst_m_len_err", bus.m_len_err, 0);
        ap_rst = 1'b0;

        // two-beat group and its latency
        send_beat(1024, 0, 0);
        send_beat(1024, 1, 0);
        chk("lat_rnd_cycle", bus.m_valid, 0);
        @(posedge ap_clk);
        #1;
        chk("lat_out_cycle", bus.m_valid, 1);
        expect_out("t1", 1, 0, 0);

        // rounding ties and bias
        send_beat(1024, 1, 0);   expect_out("rnd_p1024", 1, 0, 0);
        send_beat(1023, 1, 0);   expect_out("rnd_p1023", 0, 0, 0);
        send_beat(-1024, 1, 0);  expect_out("rnd_m1024", 0, 0, 0);
        send_beat(-1025, 1, 0);  expect_out("rnd_m1025", -1, 0, 0);
        send_beat(0, 1, 2048);   expect_out("bias2048", 1, 0, 0);

        // saturation
        send_beat(pmax, 1, 0);   expect_out("sat_hi", 32767, 1, 0);
`ifdef UNET_PVM_RELU_EN
        send_beat(pmin, 1, 0);   expect_out("sat_lo", 0, 1, 0);
`else
        send_beat(pmin, 1, 0);   expect_out("sat_lo", -32768, 1, 0);
`endif

        // backpressure hold
        send_beat(5000, 1, 0);
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            chk("hold_s_ready", bus.s_ready, 0);
            chk("hold_m_data", bus.m_data, 2);
            @(posedge ap_clk);
            #1;
        end
        expect_out("hold", 2, 0, 0);
        chk("hold_release_s_ready", bus.s_ready, 1);

        // negative group
        for (int i = 0; i < 3; i++) send_beat(-10240, i == 2, 0);
`ifdef UNET_PVM_RELU_EN
        expect_out("neg3", 0, 0, 0);
`else
        expect_out("neg3", -15, 0, 0);
`endif

        // group length limit
        for (int i = 0; i < MAX_LEN; i++) send_beat(1, i == MAX_LEN - 1, 0);
        expect_out("len_max", 0, 0, 0);
        for (int i = 0; i <= MAX_LEN; i++) send_beat(1, i == MAX_LEN, 0);
        expect_out("len_over", 1, 0, 1);

        // reset mid-group discards it
        send_beat(2048, 0, 0);
        send_beat(2048, 0, 0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_valid", bus.m_valid, 0);
            @(posedge ap_clk);
            #1;
        end
        send_beat(2048, 1, 0);
        expect_out("after_rst", 1, 0, 0);

        // random groups with idle gaps and random backpressure
        rand_mr = 1'b1;
        for (int g = 0; g < 60; g++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                idle = $urandom_range(0, 2);
                repeat (idle) begin
                    @(posedge ap_clk);
                    #1;
                end
                send_beat(rnd_prod(), b == len - 1, rnd_bias());
            end
        end
        rand_mr = 1'b0;
        bus.m_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || bus.m_valid) && n < 200) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("drain_empty", expq.size(), 0);
        bus.m_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
